// File: rtl/mem_arbiter.sv
// Arbitrates the shared block data memory between icache (read-only) and dcache (read/write).
// One requester owns memory per transfer; a dcache write-back and its refill read are kept together.
module mem_arbiter #(
    parameter int ADDR_W      = 28,
    parameter int DATA_W      = 128,
    parameter bit DC_PRIORITY = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ic_read,
    input  logic [ADDR_W-1:0] ic_address,
    output logic [DATA_W-1:0] ic_readdata,
    output logic              ic_busywait,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_address,
    input  logic [DATA_W-1:0] dc_writedata,
    output logic [DATA_W-1:0] dc_readdata,
    output logic              dc_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait,
    output logic [1:0]        owner
);
    typedef enum logic [1:0] {IDLE, IC_XFER, DC_XFER, RELEASE} state_t;

    state_t            state_q, state_d;
    logic              last_dc_q, last_dc_d;
    logic              dc_lock_q, dc_lock_d;
    logic              seen_busy_q, seen_busy_d;
    logic              after_rel_q, after_rel_d;
    logic [DATA_W-1:0] ic_rdata_q, ic_rdata_d;
    logic [DATA_W-1:0] dc_rdata_q, dc_rdata_d;
    logic              ic_req, dc_req, owner_req, xfer, ic_done, dc_done;

    assign ic_req = ic_read;
    assign dc_req = dc_read | dc_write;
    assign xfer   = (state_q == IC_XFER) || (state_q == DC_XFER);

    always_comb begin
        state_d       = state_q;
        last_dc_d     = last_dc_q;
        dc_lock_d     = dc_lock_q;
        seen_busy_d   = 1'b0;
        after_rel_d   = 1'b0;
        ic_rdata_d    = ic_rdata_q;
        dc_rdata_d    = dc_rdata_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        ic_busywait   = ic_req;
        dc_busywait   = dc_req;
        owner_req     = 1'b0;
        ic_done       = 1'b0;
        dc_done       = 1'b0;
        case (state_q)
            IDLE: begin
                // A pending lock is dropped if dcache did not follow up with its refill.
                if (after_rel_q && !dc_req) dc_lock_d = 1'b0;
                if (ic_req && dc_req) begin
                    if (dc_lock_q || DC_PRIORITY || !last_dc_q) state_d = DC_XFER;
                    else                                        state_d = IC_XFER;
                end else if (ic_req) begin
                    state_d = IC_XFER;
                end else if (dc_req) begin
                    state_d = DC_XFER;
                end
                if (state_d == DC_XFER) dc_lock_d = 1'b0;
            end
            IC_XFER: begin
                mem_read    = ic_read;
                mem_address = ic_address;
                owner_req   = ic_req;
            end
            DC_XFER: begin
                mem_read      = dc_read & ~dc_write;
                mem_write     = dc_write;
                mem_address   = dc_address;
                mem_writedata = dc_writedata;
                owner_req     = dc_req;
            end
            RELEASE: begin
                state_d     = IDLE;
                after_rel_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (xfer) begin
            seen_busy_d = seen_busy_q | mem_busywait;
            ic_done     = (state_q == IC_XFER) && owner_req && seen_busy_q && !mem_busywait;
            dc_done     = (state_q == DC_XFER) && owner_req && seen_busy_q && !mem_busywait;
            if (ic_done || dc_done || !owner_req) begin
                state_d     = RELEASE;
                seen_busy_d = 1'b0;
            end
            if (ic_done) begin
                ic_busywait = 1'b0;
                ic_rdata_d  = mem_readdata;
                last_dc_d   = 1'b0;
            end
            if (dc_done) begin
                dc_busywait = 1'b0;
                dc_rdata_d  = mem_readdata;
                last_dc_d   = 1'b1;
                if (dc_write) dc_lock_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            last_dc_q   <= 1'b0;
            dc_lock_q   <= 1'b0;
            seen_busy_q <= 1'b0;
            after_rel_q <= 1'b0;
            ic_rdata_q  <= '0;
            dc_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_dc_q   <= last_dc_d;
            dc_lock_q   <= dc_lock_d;
            seen_busy_q <= seen_busy_d;
            after_rel_q <= after_rel_d;
            ic_rdata_q  <= ic_rdata_d;
            dc_rdata_q  <= dc_rdata_d;
        end
    end

    assign ic_readdata = ic_done ? mem_readdata : ic_rdata_q;
    assign dc_readdata = dc_done ? mem_readdata : dc_rdata_q;
    assign owner       = (state_q == IC_XFER) ? 2'b01 :
                         (state_q == DC_XFER) ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_mem_arbiter.sv
// Random requesters and a random-latency memory drive two arbiters (round-robin and dcache-priority);
// a transaction-level model predicts every output each cycle.
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int W  = 128;

    logic         clock = 1'b0;
    logic         reset;
    logic         ic_read[2], dc_read[2], dc_write[2], mem_busywait[2];
    logic [AW-1:0] ic_address[2], dc_address[2], mem_address[2];
    logic [W-1:0]  dc_writedata[2], mem_readdata[2], ic_readdata[2], dc_readdata[2], mem_writedata[2];
    logic         ic_busywait[2], dc_busywait[2], mem_read[2], mem_write[2];
    logic [1:0]   owner[2];

    int total = 0;
    int bad   = 0;

    // model state: gnt 0 = nobody, 1 = icache, 2 = dcache
    int           m_gnt[2];
    bit           m_rel[2], m_win[2], m_lock[2], m_seen[2], m_last_dc[2];
    logic [W-1:0] m_rd_ic[2], m_rd_dc[2];
    bit           ic_pend[2], dc_pend[2], ic_done[2], dc_done[2], dc_was_wr[2];
    int           busy_left[2];
    int           cov_lock[2], cov_tie[2], cov_rst, cov_both[2];

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(W), .DC_PRIORITY(1'b0)) u0 (
        .clock(clock), .reset(reset),
        .ic_read(ic_read[0]), .ic_address(ic_address[0]), .ic_readdata(ic_readdata[0]), .ic_busywait(ic_busywait[0]),
        .dc_read(dc_read[0]), .dc_write(dc_write[0]), .dc_address(dc_address[0]), .dc_writedata(dc_writedata[0]),
        .dc_readdata(dc_readdata[0]), .dc_busywait(dc_busywait[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_address(mem_address[0]), .mem_writedata(mem_writedata[0]),
        .mem_readdata(mem_readdata[0]), .mem_busywait(mem_busywait[0]), .owner(owner[0]));

    mem_arbiter #(.ADDR_W(AW), .DATA_W(W), .DC_PRIORITY(1'b1)) u1 (
        .clock(clock), .reset(reset),
        .ic_read(ic_read[1]), .ic_address(ic_address[1]), .ic_readdata(ic_readdata[1]), .ic_busywait(ic_busywait[1]),
        .dc_read(dc_read[1]), .dc_write(dc_write[1]), .dc_address(dc_address[1]), .dc_writedata(dc_writedata[1]),
        .dc_readdata(dc_readdata[1]), .dc_busywait(dc_busywait[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_address(mem_address[1]), .mem_writedata(mem_writedata[1]),
        .mem_readdata(mem_readdata[1]), .mem_busywait(mem_busywait[1]), .owner(owner[1]));

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit owner_req(input int k);
        if (m_gnt[k] == 1) return ic_read[k];
        if (m_gnt[k] == 2) return dc_read[k] | dc_write[k];
        return 1'b0;
    endfunction

    function automatic bit cur_done(input int k);
        return (m_gnt[k] != 0) && owner_req(k) && m_seen[k] && !mem_busywait[k];
    endfunction

    task automatic model_reset(input int k);
        m_gnt[k] = 0; m_rel[k] = 0; m_win[k] = 0; m_lock[k] = 0; m_seen[k] = 0; m_last_dc[k] = 0;
        m_rd_ic[k] = '0; m_rd_dc[k] = '0; ic_done[k] = 0; dc_done[k] = 0;
    endtask

    task automatic check_outputs(input int k, input int cyc);
        bit           done, er, ew;
        logic [AW-1:0] ea;
        logic [W-1:0]  ewd;
        string        p;
        done = cur_done(k);
        er = 0; ew = 0; ea = '0; ewd = '0;
        if (m_gnt[k] == 1) begin
            er = ic_read[k]; ea = ic_address[k];
        end else if (m_gnt[k] == 2) begin
            ew = dc_write[k]; er = dc_read[k] && !dc_write[k]; ea = dc_address[k]; ewd = dc_writedata[k];
        end
        p = $sformatf("u%0d c%0d ", k, cyc);
        chk({p, "owner"}, W'(owner[k]), W'(m_gnt[k]));
        chk({p, "mem_read"}, W'(mem_read[k]), W'(er));
        chk({p, "mem_write"}, W'(mem_write[k]), W'(ew));
        chk({p, "mem_address"}, W'(mem_address[k]), W'(ea));
        chk({p, "mem_writedata"}, mem_writedata[k], ewd);
        chk({p, "ic_busywait"}, W'(ic_busywait[k]), W'(ic_read[k] && !(done && m_gnt[k] == 1)));
        chk({p, "dc_busywait"}, W'(dc_busywait[k]),
            W'((dc_read[k] || dc_write[k]) && !(done && m_gnt[k] == 2)));
        chk({p, "ic_readdata"}, ic_readdata[k], (done && m_gnt[k] == 1) ? mem_readdata[k] : m_rd_ic[k]);
        chk({p, "dc_readdata"}, dc_readdata[k], (done && m_gnt[k] == 2) ? mem_readdata[k] : m_rd_dc[k]);
    endtask

    // Advance the model by one clock using this cycle's inputs.
    task automatic model_step(input int k);
        bit icr, dcr, done;
        icr = ic_read[k];
        dcr = dc_read[k] | dc_write[k];
        done = cur_done(k);
        ic_done[k] = 0;
        dc_done[k] = 0;
        if (reset) begin
            model_reset(k);
            return;
        end
        if (m_gnt[k] != 0) begin
            if (done || !owner_req(k)) begin
                if (done && m_gnt[k] == 1) begin
                    m_rd_ic[k] = mem_readdata[k]; m_last_dc[k] = 0; ic_done[k] = 1;
                end else if (done) begin
                    m_rd_dc[k] = mem_readdata[k]; m_last_dc[k] = 1; dc_done[k] = 1;
                    if (dc_write[k]) begin m_lock[k] = 1; cov_lock[k]++; end
                end
                m_gnt[k] = 0; m_rel[k] = 1; m_seen[k] = 0;
            end else if (mem_busywait[k]) begin
                m_seen[k] = 1;
            end
        end else if (m_rel[k]) begin
            m_rel[k] = 0; m_win[k] = 1;
        end else begin
            if (m_win[k] && !dcr) m_lock[k] = 0;
            m_win[k] = 0;
            if (icr && dcr) begin
                cov_tie[k]++;
                m_gnt[k] = (m_lock[k] || k == 1 || !m_last_dc[k]) ? 2 : 1;
            end else if (icr) m_gnt[k] = 1;
            else if (dcr)     m_gnt[k] = 2;
            if (m_gnt[k] == 2) m_lock[k] = 0;
        end
    endtask

    task automatic drive_reqs(input int k);
        int r;
        if (ic_done[k]) ic_pend[k] = 0;
        if (!ic_pend[k] && $urandom_range(0, 2) == 0) begin
            ic_pend[k] = 1; ic_address[k] = AW'($urandom);
        end
        ic_read[k] = ic_pend[k];
        if (dc_done[k]) begin
            dc_pend[k] = 0;
            if (dc_was_wr[k] && $urandom_range(0, 1) == 1) begin
                dc_pend[k] = 1; dc_read[k] = 1; dc_write[k] = 0; dc_address[k] = AW'($urandom);
            end
        end
        if (!dc_pend[k] && $urandom_range(0, 2) == 0) begin
            r = $urandom_range(0, 5);
            dc_pend[k]      = 1;
            dc_write[k]     = (r >= 3);
            dc_read[k]      = (r < 3) || (r == 5);
            dc_address[k]   = AW'($urandom);
            dc_writedata[k] = {$urandom, $urandom, $urandom, $urandom};
            if (r == 5) cov_both[k]++;
        end
        if (!dc_pend[k]) begin dc_read[k] = 0; dc_write[k] = 0; end
        dc_was_wr[k] = dc_write[k];
    endtask

    task automatic drive_mem(input int k);
        bit active;
        active = mem_read[k] || mem_write[k];
        if (!active) busy_left[k] = $urandom_range(1, 4);
        mem_busywait[k] = active && busy_left[k] > 0;
        mem_readdata[k] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        reset = 1'b1;
        cov_rst = 0;
        for (int k = 0; k < 2; k++) begin
            ic_read[k] = 0; dc_read[k] = 0; dc_write[k] = 0; mem_busywait[k] = 0;
            ic_address[k] = '0; dc_address[k] = '0; dc_writedata[k] = '0; mem_readdata[k] = '0;
            ic_pend[k] = 0; dc_pend[k] = 0; dc_was_wr[k] = 0; busy_left[k] = 1;
            cov_lock[k] = 0; cov_tie[k] = 0; cov_both[k] = 0;
            model_reset(k);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        #2;
        for (int k = 0; k < 2; k++) begin
            check_outputs(k, -1);
            model_step(k);
        end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clock);
            reset = (cyc > 50) && ($urandom_range(0, 149) == 0);
            if (reset) cov_rst++;
            for (int k = 0; k < 2; k++) drive_reqs(k);
            #1;
            for (int k = 0; k < 2; k++) drive_mem(k);
            #1;
            for (int k = 0; k < 2; k++) begin
                check_outputs(k, cyc);
                model_step(k);
                if (mem_busywait[k] && busy_left[k] > 0) busy_left[k]--;
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d cov_lock", k), W'(cov_lock[k] > 0), W'(1));
            chk($sformatf("u%0d cov_tie", k), W'(cov_tie[k] > 0), W'(1));
            chk($sformatf("u%0d cov_both", k), W'(cov_both[k] > 0), W'(1));
        end
        chk("cov_reset", W'(cov_rst > 0), W'(1));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
